inv_key_expansion: RTL and testbench

//  Decryption-side AES-128 key schedule. Takes the final (round-10) round key and runs the
//  key recurrence backwards to regenerate all 11 round keys, ending in the cipher key.

---
 rtl/inv_key_expansion_pkg.sv | 33 +++
 rtl/inv_key_expansion_if.sv | 14 +
 rtl/inv_key_expansion_sbox.sv | 27 ++
 rtl/inv_key_expansion.sv | 120 ++++++++++++
 tb/tb_inv_key_expansion.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/inv_key_expansion_pkg.sv
// Shared constants for the AES-128 decryption-side key schedule.
// Holds the round count, the FSM state encoding and the round-constant lookup.
`timescale 1ns/1ps
package inv_key_expansion_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SUB     = 3'd2,
    ST_COMBINE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Valid for rounds 1..10; any other index has no round constant.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/inv_key_expansion_if.sv
// Control and read-port bundle of the inverse key expansion block.
// Keys use [0:127] ordering: byte 0 is bits [0:7], word 0 is bits [0:31].
`timescale 1ns/1ps
interface inv_key_expansion_if;
  logic         start;
  logic [0:127] last_key;
  logic [0:3]   rd_round;
  logic [0:127] key_out;
  logic         busy;
  logic         done;

  modport master (output start, last_key, rd_round, input key_out, busy, done);
  modport slave  (input start, last_key, rd_round, output key_out, busy, done);
endinterface

// File: rtl/inv_key_expansion_sbox.sv
// Combinational AES forward S-box; the backward key recurrence still applies SubWord.
`timescale 1ns/1ps
module sbox_module (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  assign out_byte = SBOX[in_byte];
endmodule

// File: rtl/inv_key_expansion.sv
// Regenerates all AES-128 round keys from the round-10 key, walking the schedule backwards.
// One shared S-box is time-multiplexed over the four bytes of SubWord, so each round takes 5 cycles.
//
//   state   | meaning
//   IDLE    | waiting for start after reset
//   LOAD    | capture last_key into table[10] and the working key
//   SUB     | one S-box byte per cycle of the recovered w3, idx 0..3
//   COMBINE | form the previous round key, store it, step round down
//   DONE    | table complete; read port serves table[rd_round]
`timescale 1ns/1ps
module inv_key_expansion
  import inv_key_expansion_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  inv_key_expansion_if.slave bus
);
  state_t       state;
  logic [3:0]   round;
  logic [1:0]   idx;
  logic [0:127] cur;
  logic [7:0]   sb [0:3];
  logic [0:127] key_table [0:AES_NR];
  logic [0:127] key_out_q;
  logic         busy_q;
  logic         done_q;

  logic [0:31]  w0, w1, w2, w3;
  logic [0:127] prev;
  logic [7:0]   sbox_in, sbox_out;

  always_comb begin
    w3 = cur[96:127] ^ cur[64:95];
    w2 = cur[64:95]  ^ cur[32:63];
    w1 = cur[32:63]  ^ cur[0:31];
    // RotWord is applied by reordering the already-substituted bytes.
    w0 = cur[0:31] ^ {sb[1], sb[2], sb[3], sb[0]} ^ {rcon(round), 24'h0};
    prev = {w0, w1, w2, w3};
    case (idx)
      2'd0:    sbox_in = w3[0:7];
      2'd1:    sbox_in = w3[8:15];
      2'd2:    sbox_in = w3[16:23];
      default: sbox_in = w3[24:31];
    endcase
  end

  sbox_module u_sbox (
    .in_byte  (sbox_in),
    .out_byte (sbox_out)
  );

  always_ff @(posedge clk) begin
    if (state == ST_LOAD)
      key_table[AES_NR] <= bus.last_key;
    else if (state == ST_COMBINE)
      key_table[round - 4'd1] <= prev;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      round     <= '0;
      idx       <= '0;
      cur       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      key_out_q <= '0;
      for (int i = 0; i < 4; i++) sb[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state     <= ST_LOAD;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            key_out_q <= '0;
          end
        end
        ST_LOAD: begin
          cur   <= bus.last_key;
          round <= 4'(AES_NR);
          idx   <= '0;
          state <= ST_SUB;
        end
        ST_SUB: begin
          sb[idx] <= sbox_out;
          if (idx == 2'd3) state <= ST_COMBINE;
          else             idx   <= idx + 2'd1;
        end
        ST_COMBINE: begin
          cur   <= prev;
          round <= round - 4'd1;
          idx   <= '0;
          if (round == 4'd1) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            state <= ST_SUB;
          end
        end
        ST_DONE: begin
          if (bus.start) begin
            state     <= ST_LOAD;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            key_out_q <= '0;
          end else begin
            key_out_q <= (bus.rd_round <= 4'd10) ? key_table[bus.rd_round] : '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.key_out = key_out_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_inv_key_expansion.sv
// Bench for inv_key_expansion: FIPS-197 vectors, random keys against a reference key schedule,
// busy/done cycle timing, ignored starts, mid-run reset and restart from DONE.
`timescale 1ns/1ps
module tb_inv_key_expansion;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;

  inv_key_expansion_if bus ();

  inv_key_expansion dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]   sbox_tab [0:255];
  logic [7:0]   rcon_tab [1:10];
  logic [127:0] model_rk [0:10];

  typedef struct {
    logic [127:0] lk;
    logic [3:0]   rd;
    logic [127:0] exp;
    string        name;
  } vec_t;
  vec_t vecs [4];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rcon_tab[1] = 8'h01;
    for (int i = 2; i <= 10; i++) rcon_tab[i] = xtime(rcon_tab[i-1]);
  endtask

  function automatic logic [31:0] g_word(input logic [31:0] x, input int r);
    logic [31:0] rot = {x[23:0], x[31:24]};
    return {sbox_tab[rot[31:24]], sbox_tab[rot[23:16]], sbox_tab[rot[15:8]], sbox_tab[rot[7:0]]}
           ^ {rcon_tab[r], 24'h0};
  endfunction

  task automatic build_model(input logic [127:0] lk);
    logic [31:0] w [0:43];
    for (int j = 0; j < 4; j++) w[40+j] = lk[127-32*j -: 32];
    for (int i = 43; i >= 4; i--)
      w[i-4] = w[i] ^ ((i % 4 == 0) ? g_word(w[i-1], i/4) : w[i-1]);
    for (int r = 0; r <= 10; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] fwd_last(input logic [127:0] k);
    logic [31:0] w [0:43];
    for (int j = 0; j < 4; j++) w[j] = k[127-32*j -: 32];
    for (int i = 4; i < 44; i++)
      w[i] = w[i-4] ^ ((i % 4 == 0) ? g_word(w[i-1], i/4) : w[i-1]);
    return {w[40], w[41], w[42], w[43]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Starts a run and checks busy/done on every edge up to done; optionally fires extra starts.
  task automatic run_exp(input string tag, input logic [127:0] key, input bit inject);
    @(negedge clk);
    bus.last_key = key;
    bus.start = 1'b1;
    for (int k = 0; k <= 51; k++) begin
      @(posedge clk); #1;
      if (k <= 50) begin
        chk($sformatf("%s_busy_e%0d", tag, k), 128'(bus.busy), 128'(1));
        chk($sformatf("%s_done_e%0d", tag, k), 128'(bus.done), 128'(0));
      end else begin
        chk($sformatf("%s_busy_end", tag), 128'(bus.busy), 128'(0));
        chk($sformatf("%s_done_end", tag), 128'(bus.done), 128'(1));
      end
      if (k == 0 || k == 25) chk($sformatf("%s_keyout0_e%0d", tag, k), bus.key_out, 128'(0));
      @(negedge clk);
      bus.start = inject && (k + 1 == 3 || k + 1 == 20 || k + 1 == 40);
      if (k == 1) bus.last_key = rand128();
    end
    bus.start = 1'b0;
  endtask

  task automatic read_round(input int r, output logic [127:0] v);
    @(negedge clk);
    bus.rd_round = 4'(r);
    @(posedge clk); #1;
    v = bus.key_out;
  endtask

  task automatic sweep(input string tag);
    logic [127:0] v;
    for (int r = 10; r >= 0; r--) begin
      read_round(r, v);
      chk($sformatf("%s_rk%0d", tag, r), v, model_rk[r]);
    end
    for (int r = 11; r <= 15; r++) begin
      read_round(r, v);
      chk($sformatf("%s_oor%0d", tag, r), v, 128'(0));
    end
  endtask

  localparam logic [127:0] FIPS_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  initial begin
    logic [127:0] v;
    logic [127:0] k;

    bus.start = 1'b0;
    bus.last_key = '0;
    bus.rd_round = '0;
    build_tables();

    vecs[0] = '{FIPS_LAST, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, "fips_rk0"};
    vecs[1] = '{FIPS_LAST, 4'd9,  128'hac7766f319fadc2128d12941575c006e, "fips_rk9"};
    vecs[2] = '{FIPS_LAST, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "fips_rk1"};
    vecs[3] = '{FIPS_LAST, 4'd10, FIPS_LAST,                             "fips_rk10"};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_done", 128'(bus.done), 128'(0));
    chk("rst_keyout", bus.key_out, 128'(0));
    @(negedge clk);
    reset = 1'b0;

    // FIPS-197 key, first plainly, then with starts fired while busy.
    for (int pass = 0; pass < 2; pass++) begin
      run_exp($sformatf("fips%0d", pass), FIPS_LAST, pass == 1);
      for (int i = 0; i < 4; i++) begin
        read_round(int'(vecs[i].rd), v);
        chk($sformatf("%s_p%0d", vecs[i].name, pass), v, vecs[i].exp);
      end
      build_model(FIPS_LAST);
      sweep($sformatf("fips%0d", pass));
    end

    // Random keys, each run restarting from DONE.
    for (int t = 0; t < 3; t++) begin
      k = rand128();
      build_model(k);
      run_exp($sformatf("rnd%0d", t), k, 1'b0);
      sweep($sformatf("rnd%0d", t));
    end

    // Reset while in SUB of round 6, then expand an all-zero round-10 key.
    @(negedge clk);
    bus.last_key = rand128();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    chk("pre_rst_busy", 128'(bus.busy), 128'(1));
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", 128'(bus.busy), 128'(0));
    chk("midrst_done", 128'(bus.done), 128'(0));
    chk("midrst_keyout", bus.key_out, 128'(0));
    @(negedge clk);
    reset = 1'b0;
    build_model(128'h0);
    run_exp("zero", 128'h0, 1'b0);
    read_round(0, v);
    chk("zero_fwd_last", fwd_last(v), 128'h0);
    sweep("zero");

    // Restart from DONE with a fresh key.
    k = rand128();
    build_model(k);
    run_exp("restart", k, 1'b0);
    sweep("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1);
  end
endmodule
